// File: rtl/systolic_array_pkg.sv
// Shared TPU sizing: operand/accumulator widths, array dimension and row-index width,
// used by the operand memories, the control FSM and the systolic array.
package systolic_array_pkg;

  localparam int TPU_BITS_AB = 8;
  localparam int TPU_BITS_C  = 16;
  localparam int TPU_DIM     = 8;

  // Row index needs at least one bit even for a 1x1 array.
  function automatic int row_w(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

  localparam int TPU_ROW_W = row_w(TPU_DIM);

endpackage

// File: rtl/systolic_array_tc.sv
// One processing element: forwards A right and B down, MACs into a local accumulator.
// Latency: one enabled cycle per hop; en=0 freezes all state; a local write overrides the MAC.
module systolic_array_tc
  import systolic_array_pkg::*;
#(
  parameter int BITS_AB = TPU_BITS_AB,
  parameter int BITS_C  = TPU_BITS_C
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               WrEn,
  input  logic [BITS_C-1:0]  Cin,
  input  logic [BITS_AB-1:0] Ain,
  input  logic [BITS_AB-1:0] Bin,
  output logic [BITS_AB-1:0] Aout,
  output logic [BITS_AB-1:0] Bout,
  output logic [BITS_C-1:0]  Cout
);

  localparam int PW = 2 * BITS_AB;

  logic [BITS_AB-1:0] a_q;
  logic [BITS_AB-1:0] b_q;
  logic [BITS_C-1:0]  acc;
  logic [PW-1:0]      prod;
  logic [BITS_C-1:0]  prod_c;

  assign prod = $signed(Ain) * $signed(Bin);

  // Fit the full-precision product to the accumulator width; the sum then wraps.
  if (BITS_C > PW) begin : g_sext
    assign prod_c = {{(BITS_C - PW){prod[PW-1]}}, prod};
  end else if (BITS_C == PW) begin : g_same
    assign prod_c = prod;
  end else begin : g_trunc
    assign prod_c = prod[BITS_C-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
    end else begin
      if (en) begin
        a_q <= Ain;
        b_q <= Bin;
      end
      if (WrEn) begin
        acc <= Cin;
      end else if (en) begin
        acc <= acc + prod_c;
      end
    end
  end

  assign Aout = a_q;
  assign Bout = b_q;
  assign Cout = acc;

endmodule

// File: rtl/systolic_array.sv
// DIM x DIM output-stationary MAC grid with row-addressed accumulator preload and readback.
// Latency: full product after 3*DIM-2 enabled cycles; en=0 stalls the whole grid in lockstep.
module systolic_array
  import systolic_array_pkg::*;
#(
  parameter int  BITS_AB = TPU_BITS_AB,
  parameter int  BITS_C  = TPU_BITS_C,
  parameter int  DIM     = TPU_DIM,
  localparam int ROW_W   = row_w(DIM)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    WrEn,
  input  logic                    en,
  input  logic [DIM*BITS_AB-1:0]  A,
  input  logic [DIM*BITS_AB-1:0]  B,
  input  logic [ROW_W-1:0]        Crow,
  input  logic [DIM*BITS_C-1:0]   Cin,
  output logic [DIM*BITS_C-1:0]   Cout
);

  logic [BITS_AB-1:0] a_q [DIM][DIM];
  logic [BITS_AB-1:0] b_q [DIM][DIM];
  logic [BITS_C-1:0]  acc [DIM][DIM];
  logic [DIM-1:0]     row_wr;

  // Out-of-range Crow (non-power-of-2 DIM) matches no row, so the write is dropped.
  for (genvar r = 0; r < DIM; r++) begin : g_wdec
    assign row_wr[r] = WrEn && (Crow == ROW_W'(r));
  end

  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [BITS_AB-1:0] a_in;
      logic [BITS_AB-1:0] b_in;

      if (c == 0) begin : g_aedge
        assign a_in = A[r*BITS_AB +: BITS_AB];
      end else begin : g_ahop
        assign a_in = a_q[r][c-1];
      end

      if (r == 0) begin : g_bedge
        assign b_in = B[c*BITS_AB +: BITS_AB];
      end else begin : g_bhop
        assign b_in = b_q[r-1][c];
      end

      systolic_array_tc #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
      ) u_tc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .WrEn  (row_wr[r]),
        .Cin   (Cin[c*BITS_C +: BITS_C]),
        .Ain   (a_in),
        .Bin   (b_in),
        .Aout  (a_q[r][c]),
        .Bout  (b_q[r][c]),
        .Cout  (acc[r][c])
      );
    end
  end

  always_comb begin
    Cout = '0;
    for (int r = 0; r < DIM; r++) begin
      if (Crow == ROW_W'(r)) begin
        for (int c = 0; c < DIM; c++) begin
          Cout[c*BITS_C +: BITS_C] = acc[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array.sv
// Directed bench for systolic_array: a stream-level matrix model checked every cycle,
// plus hand-computed result rows for each scenario.
module tb_systolic_array;
  import systolic_array_pkg::*;

  localparam int N    = TPU_DIM;
  localparam int W    = TPU_BITS_AB;
  localparam int CW   = TPU_BITS_C;
  localparam int RW   = TPU_ROW_W;
  localparam int NCYC = 3 * N - 2;
  localparam int HMAX = 1024;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            WrEn  = 1'b0;
  logic            en    = 1'b0;
  logic [N*W-1:0]  A     = '0;
  logic [N*W-1:0]  B     = '0;
  logic [RW-1:0]   Crow  = '0;
  logic [N*CW-1:0] Cin   = '0;
  logic [N*CW-1:0] Cout;

  int nvec = 0;
  int nbad = 0;
  bit chk_on = 1'b0;

  int am [N][N];
  int bm [N][N];

  // Model: history of every enabled-cycle edge input, and the accumulator matrix.
  logic [N*W-1:0]       ha [HMAX];
  logic [N*W-1:0]       hb [HMAX];
  int                   tcnt = 0;
  logic signed [CW-1:0] accm [N][N];

  systolic_array dut (
    .clk   (clk),
    .rst_n (rst_n),
    .WrEn  (WrEn),
    .en    (en),
    .A     (A),
    .B     (B),
    .Crow  (Crow),
    .Cin   (Cin),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  // Value of edge stream row/col `idx` entered at enabled cycle t (zero before it existed).
  function automatic int a_at(input int idx, input int t);
    if (t < 0) return 0;
    return int'($signed(ha[t][idx*W +: W]));
  endfunction

  function automatic int b_at(input int idx, input int t);
    if (t < 0) return 0;
    return int'($signed(hb[t][idx*W +: W]));
  endfunction

  // A value entering row i reaches column j after j hops; B entering column j reaches row i after i hops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          accm[i][j] = '0;
    end else begin
      if (en && tcnt < HMAX) begin
        ha[tcnt] = A;
        hb[tcnt] = B;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (!(WrEn && int'(Crow) == i))
              accm[i][j] = CW'(int'(accm[i][j]) + a_at(i, tcnt - j) * b_at(j, tcnt - i));
        tcnt++;
      end
      if (WrEn && int'(Crow) < N)
        for (int j = 0; j < N; j++)
          accm[int'(Crow)][j] = Cin[j*CW +: CW];
    end
  end

  function automatic logic [N*CW-1:0] model_row(input int r);
    logic [N*CW-1:0] e;
    e = '0;
    if (r < N)
      for (int c = 0; c < N; c++)
        e[c*CW +: CW] = accm[r][c];
    return e;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      logic [N*CW-1:0] e;
      e = model_row(int'(Crow));
      nvec++;
      if (Cout !== e) begin
        nbad++;
        $display("FAIL model row %0d: got %h expected %h", Crow, Cout, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expected values, independent of the model.
  function automatic int exp_val(input int mode, input int r, input int c);
    case (mode)
      1:       return r * 8 + c;
      2:       return -48;
      3:       return (r == 3) ? 100 + 24 + c : r * 8 + c;
      default: return 0;
    endcase
  endfunction

  task automatic check_lit(input string name, input int mode);
    logic [N*CW-1:0] e;
    en   = 1'b0;
    WrEn = 1'b0;
    for (int r = 0; r < N; r++) begin
      Crow = RW'(r);
      for (int c = 0; c < N; c++)
        e[c*CW +: CW] = CW'(exp_val(mode, r, c));
      #2;
      nvec++;
      if (Cout !== e) begin
        nbad++;
        $display("FAIL %s row %0d: got %h expected %h", name, r, Cout, e);
      end
      tick();
    end
  endtask

  task automatic zero_acc();
    en  = 1'b0;
    Cin = '0;
    for (int r = 0; r < N; r++) begin
      WrEn = 1'b1;
      Crow = RW'(r);
      tick();
    end
    WrEn = 1'b0;
  endtask

  task automatic write_row(input int r, input int v);
    en = 1'b0;
    for (int c = 0; c < N; c++)
      Cin[c*CW +: CW] = CW'(v);
    WrEn = 1'b1;
    Crow = RW'(r);
    tick();
    WrEn = 1'b0;
    Cin  = '0;
  endtask

  task automatic set_mats(input int kind);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        case (kind)
          0: begin am[i][j] = (i == j) ? 1 : 0; bm[i][j] = i * N + j; end
          1: begin am[i][j] = -128;             bm[i][j] = -128;      end
          default: begin am[i][j] = 3;          bm[i][j] = -2;        end
        endcase
  endtask

  function automatic int skew_a(input int r, input int t);
    int k;
    k = t - r;
    return (k >= 0 && k < N) ? am[r][k] : 0;
  endfunction

  function automatic int skew_b(input int c, input int t);
    int k;
    k = t - c;
    return (k >= 0 && k < N) ? bm[k][c] : 0;
  endfunction

  // Feeds a skewed product; optionally stalls gap_len cycles at enabled cycle gap_at,
  // or asserts reset at cycle rst_at and abandons the run.
  task automatic run_product(input int gap_at, input int gap_len, input int rst_at);
    int t    = 0;
    int cyc  = 0;
    int gaps = 0;
    while (t < NCYC) begin
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        return;
      end
      Crow = RW'(cyc % N);
      if (t == gap_at && gaps < gap_len) begin
        en = 1'b0;
        A  = {N{8'h5a}};
        B  = {N{8'ha5}};
        gaps++;
      end else begin
        en = 1'b1;
        for (int i = 0; i < N; i++) begin
          A[i*W +: W] = W'(skew_a(i, t));
          B[i*W +: W] = W'(skew_b(i, t));
        end
        t++;
      end
      tick();
      cyc++;
    end
    en = 1'b0;
    A  = '0;
    B  = '0;
  endtask

  initial begin
    repeat (2) tick();
    rst_n  = 1'b1;
    chk_on = 1'b1;
    tick();
    check_lit("reset", 0);

    zero_acc();
    set_mats(0);
    run_product(-1, 0, -1);
    check_lit("identity", 1);

    zero_acc();
    set_mats(1);
    run_product(-1, 0, -1);
    check_lit("wrap", 0);

    zero_acc();
    set_mats(2);
    run_product(-1, 0, -1);
    check_lit("negative", 2);

    zero_acc();
    write_row(3, 100);
    set_mats(0);
    run_product(-1, 0, -1);
    check_lit("preload", 3);

    zero_acc();
    run_product(10, 5, -1);
    check_lit("en_gap", 1);

    zero_acc();
    run_product(-1, 0, 12);
    check_lit("mid_reset", 0);
    run_product(-1, 0, -1);
    check_lit("rerun", 1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/systolic_array.md
# systolic_array

DIM×DIM output-stationary systolic multiply-accumulate array. It is the compute stage directly downstream of the skewed A and B operand memories: it consumes one skewed A column-slice (left edge) and one skewed B row-slice (top edge) per enabled cycle and accumulates C = C + A×B in place. Accumulators are preloaded and read back one row at a time through the C row port, which is driven by the host-side control FSM.

## Interface
- BITS_AB, 8, signed width of A and B operands
- BITS_C, 16, signed width of each accumulator
- DIM, 8, array dimension (rows = columns = DIM)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- WrEn  in  1  write Cin into accumulator row Crow this cycle
- en  in  1  advance operand pipelines and accumulate
- A  in  BITS_AB×DIM  signed; A[r] enters the left edge of row r (already skewed upstream)
- B  in  BITS_AB×DIM  signed; B[c] enters the top edge of column c (already skewed upstream)
- Crow  in  $clog2(DIM)  accumulator row selected for write and read
- Cin  in  BITS_C×DIM  signed; values written to row Crow, Cin[c] → column c
- Cout  out  BITS_C×DIM  signed; current accumulators of row Crow

## Operation
- PE(r,c) holds three registers: a_q, b_q (BITS_AB), acc (BITS_C).
- PE inputs: a_in = A[r] for c=0, else a_q of PE(r,c-1); b_in = B[c] for r=0, else b_q of PE(r-1,c).
- en=1: a_q←a_in, b_q←b_in, acc←acc + sext(a_in)×sext(b_in) in every PE not being written.
- en=0: all a_q, b_q, acc hold.
- Product: full 2·BITS_AB signed, sign-extended (or truncated if BITS_C<2·BITS_AB) to BITS_C; sum wraps modulo 2^BITS_C, no saturation, no overflow flag.
- WrEn=1: acc of every PE in row Crow ← Cin[c]; overrides accumulation for that row in the same cycle. a_q/b_q of that row still advance if en=1.
- Simultaneous WrEn and en: written row takes Cin, all other rows accumulate.
- Cout[c] = acc of PE(Crow,c), combinational from registers and Crow; reflects a write on the cycle after WrEn.
- Crow ≥ DIM (non-power-of-2 DIM): write ignored, Cout = 0.
- Clearing before a new product is done by writing zeros to each row (DIM WrEn cycles); no global clear besides reset.

## Timing
- Reset: all a_q, b_q, acc = 0; Cout = 0 for every Crow.
- Operand hop latency: one enabled cycle per PE horizontally and vertically.
- With upstream skew (row r of A and column c of B delayed r and c cycles), A[i][k] and B[k][j] meet in PE(i,j) at enabled cycle i+j+k counted from the first enabled cycle.
- Full product valid after 3·DIM−2 enabled cycles (22 for DIM=8); 0 extra cycles for Cout readout beyond Crow settling.
- en gaps stretch the schedule but do not corrupt it (all state freezes together).
- Reset asserted mid-operation: all state clears immediately; partial sums are lost; no recovery required.

## Structure
- Shared package (tpu-wide): BITS_AB, BITS_C, DIM defaults and the row-index width constant, shared with the A/B operand memories and the control FSM.
- One sub-module: systolic_array_tc (single PE: a_q/b_q/acc, MAC, local WrEn/Cin load, Aout/Bout/Cout). The top is a generate grid of DIM×DIM instances plus the Crow write-decode and read mux.

## Test plan
- Reset, then sweep Crow 0..DIM−1 with en=0 → Cout all 0 for every row.
- A = identity, B = matrix with B[k][j] = k·DIM+j, correctly skewed, accumulators zeroed → after 22 enabled cycles row r reads r·8+0 … r·8+7.
- A all −128, B all −128 with BITS_C=16, DIM=8 → each acc = 8·16384 = 131072 mod 2^16 = 0 (wrap checked); with A all 3, B all −2 → each acc = −48.
- WrEn row 3 with Cin all 100, then same identity×B run → row 3 reads 100+24+j, other rows unchanged from the plain result.
- Insert en=0 for 5 cycles at cycle 10 of the identity run → final result identical, Cout stable during the gap.
- Assert rst_n=0 at cycle 12 of a run → all Cout = 0 next read; rerun from zeroed state gives the correct product.
